// File: rtl/mem_req_pkg.sv
// ============================================================================
// Module      : mem_req_pkg
// Description : Shared constants for the memory request sequencer. Holds the
//               two-bit FSM state encoding and the default parameter values
//               used by mem_req_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_req_pkg;

    // FSM state encoding
    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_ISSUE = 2'd1;
    localparam logic [1:0] c_ST_WAIT  = 2'd2;
    localparam logic [1:0] c_ST_RESP  = 2'd3;

    // Default parameter values
    localparam int c_TIMEOUT_CYC_DEF = 64;
    localparam int c_CNT_W_DEF       = 16;

endpackage

`default_nettype wire

// File: rtl/mem_req_sat_cnt.sv
// ============================================================================
// Module      : mem_req_sat_cnt
// Description : Saturating up-counter. Adds one on each cycle where inc is
//               high and holds at all-ones once it gets there.
// Ports       : clk   - clock
//               rst   - asynchronous active-low clear
//               inc   - increment request
//               count - current count value (CNT_W bits)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_req_sat_cnt #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= '0;
        end else if (inc && (r_count != '1)) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign count = r_count;

endmodule

`default_nettype wire

// File: rtl/mem_req_ctrl.sv
// ============================================================================
// Module      : mem_req_ctrl
// Description : Sequencer between the pipeline memory stage and mem_system.
//               Accepts one load/store, issues a single-cycle Rd/Wr pulse
//               while mem_system is not stalled, waits for Done (bounded by
//               TIMEOUT_CYC) and returns a one-cycle response. Misaligned
//               addresses are answered with an error without any access.
// Config      : MEM_REQ_PERF_EN - when defined, perf_hits/perf_misses count
//               error-free responses (saturating); otherwise both read 0.
// Ports       : clk, rst (async active-low)
//               req_valid/req_wr/req_addr/req_wdata/req_ready - pipeline req
//               resp_valid/resp_rdata/resp_hit/resp_err      - response
//               stall_pipe                                   - pipeline freeze
//               mem_addr/mem_datain/mem_rd/mem_wr            - to mem_system
//               mem_done/mem_stall/mem_dataout/mem_hit       - from mem_system
//               perf_hits/perf_misses                        - counters
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_req_ctrl
    import mem_req_pkg::*;
#(
    parameter int TIMEOUT_CYC = c_TIMEOUT_CYC_DEF,
    parameter int CNT_W       = c_CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    input  logic             req_wr,
    input  logic [15:0]      req_addr,
    input  logic [15:0]      req_wdata,
    output logic             req_ready,
    output logic             resp_valid,
    output logic [15:0]      resp_rdata,
    output logic             resp_hit,
    output logic             resp_err,
    output logic             stall_pipe,
    output logic [15:0]      mem_addr,
    output logic [15:0]      mem_datain,
    output logic             mem_rd,
    output logic             mem_wr,
    input  logic             mem_done,
    input  logic             mem_stall,
    input  logic [15:0]      mem_dataout,
    input  logic             mem_hit,
    output logic [CNT_W-1:0] perf_hits,
    output logic [CNT_W-1:0] perf_misses
);

    // Timeout counter only has to reach TIMEOUT_CYC-1.
    localparam int                c_TO_W    = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [c_TO_W-1:0] c_TO_LAST = c_TO_W'(TIMEOUT_CYC - 1);

    logic [1:0]        r_state;
    logic [1:0]        w_state_next;
    logic              r_wr;
    logic [15:0]       r_addr;
    logic [15:0]       r_wdata;
    logic [c_TO_W-1:0] r_to_cnt;
    logic [c_TO_W-1:0] w_to_next;
    logic [15:0]       r_rdata;
    logic              r_hit;
    logic              r_err;

    logic              w_accept;
    logic              w_issue;
    logic              w_done_cap;
    logic              w_fail;

    assign w_to_next = r_to_cnt + c_TO_W'(1);

    // Next-state and control strobes
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_issue      = 1'b0;
        w_done_cap   = 1'b0;
        w_fail       = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                if (req_valid) begin
                    w_accept = 1'b1;
                    if (req_addr[0]) begin
                        w_fail       = 1'b1;
                        w_state_next = c_ST_RESP;
                    end else begin
                        w_state_next = c_ST_ISSUE;
                    end
                end
            end
            c_ST_ISSUE: begin
                if (!mem_stall) begin
                    w_issue = 1'b1;
                    // A store hit may complete in the pulse cycle itself;
                    // WAIT is skipped so the response is not delayed.
                    if (mem_done) begin
                        w_done_cap   = 1'b1;
                        w_state_next = c_ST_RESP;
                    end else begin
                        w_state_next = c_ST_WAIT;
                    end
                end
            end
            c_ST_WAIT: begin
                if (mem_done) begin
                    w_done_cap   = 1'b1;
                    w_state_next = c_ST_RESP;
                end else if (w_to_next == c_TO_LAST) begin
                    // Response lands exactly TIMEOUT_CYC cycles after the pulse.
                    w_fail       = 1'b1;
                    w_state_next = c_ST_RESP;
                end
            end
            c_ST_RESP: begin
                w_state_next = c_ST_IDLE;
            end
            default: begin
                w_state_next = c_ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= c_ST_IDLE;
            r_wr     <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_to_cnt <= '0;
            r_rdata  <= '0;
            r_hit    <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_state <= w_state_next;

            if (w_accept) begin
                r_wr    <= req_wr;
                r_addr  <= req_addr;
                r_wdata <= req_wdata;
            end

            if (r_state == c_ST_WAIT) begin
                r_to_cnt <= w_to_next;
            end else begin
                r_to_cnt <= '0;
            end

            if (w_done_cap) begin
                r_hit <= mem_hit;
                r_err <= 1'b0;
                if (!r_wr) begin
                    r_rdata <= mem_dataout;
                end
            end else if (w_fail) begin
                r_hit <= 1'b0;
                r_err <= 1'b1;
            end
        end
    end

    // Strobes decode from the state register so a reset drops them at once.
    assign req_ready  = (r_state == c_ST_IDLE);
    assign resp_valid = (r_state == c_ST_RESP);
    assign stall_pipe = (r_state != c_ST_IDLE);
    assign mem_rd     = w_issue & ~r_wr;
    assign mem_wr     = w_issue &  r_wr;
    assign mem_addr   = r_addr;
    assign mem_datain = r_wdata;
    assign resp_rdata = r_rdata;
    assign resp_hit   = r_hit;
    assign resp_err   = r_err;

`ifdef MEM_REQ_PERF_EN
    logic w_inc_hit;
    logic w_inc_miss;

    assign w_inc_hit  = resp_valid & ~r_err &  r_hit;
    assign w_inc_miss = resp_valid & ~r_err & ~r_hit;

    mem_req_sat_cnt #(
        .CNT_W (CNT_W)
    ) u_hit_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (w_inc_hit),
        .count (perf_hits)
    );

    mem_req_sat_cnt #(
        .CNT_W (CNT_W)
    ) u_miss_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (w_inc_miss),
        .count (perf_misses)
    );
`else
    assign perf_hits   = '0;
    assign perf_misses = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mem_req_ctrl.sv
// ============================================================================
// Module      : tb_mem_req_ctrl
// Description : Self-checking bench for mem_req_ctrl. Directed transactions
//               push their expected response into a queue; a monitor pops
//               and compares on every resp_valid. A second instance with
//               CNT_W=2 shares all inputs to exercise counter saturation.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_req_ctrl;

    localparam int c_TO = 8;

    typedef struct packed {
        logic [15:0] rdata;
        logic        hit;
        logic        err;
    } resp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_wr = 1'b0;
    logic [15:0] req_addr = '0;
    logic [15:0] req_wdata = '0;
    logic        mem_done = 1'b0;
    logic        mem_stall = 1'b0;
    logic [15:0] mem_dataout = '0;
    logic        mem_hit = 1'b0;

    logic        req_ready, resp_valid, resp_hit, resp_err, stall_pipe;
    logic        mem_rd, mem_wr;
    logic [15:0] resp_rdata, mem_addr, mem_datain;
    logic [15:0] perf_hits, perf_misses;

    logic        d2_req_ready, d2_resp_valid, d2_resp_hit, d2_resp_err, d2_stall_pipe;
    logic        d2_mem_rd, d2_mem_wr;
    logic [15:0] d2_resp_rdata, d2_mem_addr, d2_mem_datain;
    logic [1:0]  d2_perf_hits, d2_perf_misses;

    resp_t exp_q[$];
    resp_t m_exp;
    int    n_checks = 0;
    int    n_errors = 0;
    int    rd_pulses = 0;
    int    wr_pulses = 0;
    int    p0;
    int    k;
    int    e_hits, e_misses, e2_hits;

    mem_req_ctrl #(.TIMEOUT_CYC(c_TO), .CNT_W(16)) u_dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_wr(req_wr), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_hit(resp_hit), .resp_err(resp_err), .stall_pipe(stall_pipe),
        .mem_addr(mem_addr), .mem_datain(mem_datain), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .mem_done(mem_done), .mem_stall(mem_stall), .mem_dataout(mem_dataout), .mem_hit(mem_hit),
        .perf_hits(perf_hits), .perf_misses(perf_misses)
    );

    mem_req_ctrl #(.TIMEOUT_CYC(c_TO), .CNT_W(2)) u_dut2 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_wr(req_wr), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(d2_req_ready), .resp_valid(d2_resp_valid), .resp_rdata(d2_resp_rdata),
        .resp_hit(d2_resp_hit), .resp_err(d2_resp_err), .stall_pipe(d2_stall_pipe),
        .mem_addr(d2_mem_addr), .mem_datain(d2_mem_datain), .mem_rd(d2_mem_rd), .mem_wr(d2_mem_wr),
        .mem_done(mem_done), .mem_stall(mem_stall), .mem_dataout(mem_dataout), .mem_hit(mem_hit),
        .perf_hits(d2_perf_hits), .perf_misses(d2_perf_misses)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic resp_t mk(input logic [15:0] d, input logic h, input logic e);
        mk = {d, h, e};
    endfunction

    // Response monitor / scoreboard
    always @(negedge clk) begin
        if (mem_rd) rd_pulses++;
        if (mem_wr) wr_pulses++;
        if (resp_valid) begin
            if (exp_q.size() == 0) begin
                check("resp_unexpected", 32'(resp_valid), 32'd0);
            end else begin
                m_exp = exp_q.pop_front();
                check("resp_rdata", 32'(resp_rdata), 32'(m_exp.rdata));
                check("resp_hit",   32'(resp_hit),   32'(m_exp.hit));
                check("resp_err",   32'(resp_err),   32'(m_exp.err));
                check("stall_at_resp", 32'(stall_pipe), 32'd1);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a request for one cycle; returns #1 after the accepting edge.
    task automatic issue(input logic wr, input logic [15:0] addr, input logic [15:0] wd);
        req_valid = 1'b1;
        req_wr    = wr;
        req_addr  = addr;
        req_wdata = wd;
        @(negedge clk);
        check("req_ready_accept", 32'(req_ready), 32'd1);
        tick();
        req_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (req_ready) break;
        end
        check(name, 32'(req_ready), 32'd1);
        tick();
    endtask

    // Load completing one cycle after its Rd pulse
    task automatic txn_load(input logic [15:0] addr, input logic [15:0] data, input logic hit);
        exp_q.push_back(mk(data, hit, 1'b0));
        issue(1'b0, addr, 16'h0);
        tick();
        mem_done    = 1'b1;
        mem_hit     = hit;
        mem_dataout = data;
        tick();
        mem_done = 1'b0;
        wait_idle("txn_idle");
    endtask

    initial begin
        // Reset state
        @(negedge clk);
        check("rst_req_ready",  32'(req_ready),  32'd1);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_mem_rdwr",   32'({mem_rd, mem_wr}), 32'd0);
        check("rst_stall",      32'(stall_pipe), 32'd0);
        check("rst_rdata",      32'(resp_rdata), 32'd0);
        check("rst_mem_addr",   32'(mem_addr),   32'd0);
        check("rst_perf",       32'({perf_hits, perf_misses}), 32'd0);
        tick();
        rst = 1'b1;
        tick();

        // Load hit, Done two cycles after the Rd pulse
        p0 = rd_pulses;
        exp_q.push_back(mk(16'hBEEF, 1'b1, 1'b0));
        issue(1'b0, 16'h0010, 16'h0);
        @(negedge clk);
        check("ld_rd_pulse", 32'(mem_rd), 32'd1);
        check("ld_addr",     32'(mem_addr), 32'h0010);
        check("ld_stall",    32'(stall_pipe), 32'd1);
        tick();
        @(negedge clk);
        check("ld_rd_low_wait", 32'(mem_rd), 32'd0);
        tick();
        mem_done = 1'b1; mem_hit = 1'b1; mem_dataout = 16'hBEEF;
        @(negedge clk);
        check("ld_stall_wait", 32'(stall_pipe), 32'd1);
        tick();
        mem_done = 1'b0;
        wait_idle("ld_idle");
        check("ld_rd_count", 32'(rd_pulses - p0), 32'd1);
        check("ld_stall_idle", 32'(stall_pipe), 32'd0);

        // Store hit with Done in the Wr pulse cycle; rdata untouched
        p0 = wr_pulses;
        exp_q.push_back(mk(16'hBEEF, 1'b1, 1'b0));
        issue(1'b1, 16'h0024, 16'h1234);
        mem_done = 1'b1; mem_hit = 1'b1; mem_dataout = 16'hFFFF;
        @(negedge clk);
        check("st_wr_pulse", 32'(mem_wr), 32'd1);
        check("st_addr",     32'(mem_addr), 32'h0024);
        check("st_datain",   32'(mem_datain), 32'h1234);
        tick();
        mem_done = 1'b0;
        @(negedge clk);
        check("st_resp_next", 32'(resp_valid), 32'd1);
        wait_idle("st_idle");
        check("st_wr_count", 32'(wr_pulses - p0), 32'd1);

        // Accept while mem_system stalls for 5 cycles
        mem_stall = 1'b1;
        p0 = rd_pulses;
        exp_q.push_back(mk(16'h5A5A, 1'b0, 1'b0));
        issue(1'b0, 16'h0030, 16'h0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_no_pulse", 32'({mem_rd, mem_wr}), 32'd0);
            tick();
        end
        mem_stall = 1'b0;
        @(negedge clk);
        check("stall_release_pulse", 32'(mem_rd), 32'd1);
        tick();
        mem_done = 1'b1; mem_hit = 1'b0; mem_dataout = 16'h5A5A;
        tick();
        mem_done = 1'b0;
        wait_idle("stall_idle");
        check("stall_rd_count", 32'(rd_pulses - p0), 32'd1);

        // Misaligned load
        p0 = rd_pulses + wr_pulses;
        exp_q.push_back(mk(16'h5A5A, 1'b0, 1'b1));
        issue(1'b0, 16'h0013, 16'h0);
        @(negedge clk);
        check("mis_resp_next", 32'(resp_valid), 32'd1);
        wait_idle("mis_idle");
        check("mis_no_access", 32'(rd_pulses + wr_pulses - p0), 32'd0);

        // Timeout: Done never arrives
        exp_q.push_back(mk(16'h5A5A, 1'b0, 1'b1));
        issue(1'b0, 16'h0040, 16'h0);
        @(negedge clk);
        check("to_rd_pulse", 32'(mem_rd), 32'd1);
        for (k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (resp_valid) break;
        end
        check("to_latency", 32'(k), 32'(c_TO));
        wait_idle("to_idle");

        // Done while idle is ignored
        mem_done = 1'b1;
        tick();
        tick();
        mem_done = 1'b0;
        @(negedge clk);
        check("idle_done_ignored", 32'(resp_valid), 32'd0);
        tick();

        // Counters: 3 hits + 2 misses so far, then 2 more hits
        txn_load(16'h0050, 16'h1111, 1'b1);
        txn_load(16'h0052, 16'h2222, 1'b0);
`ifdef MEM_REQ_PERF_EN
        e_hits = 3; e_misses = 2; e2_hits = 3;
`else
        e_hits = 0; e_misses = 0; e2_hits = 0;
`endif
        check("perf_hits_3",   32'(perf_hits),   32'(e_hits));
        check("perf_misses_2", 32'(perf_misses), 32'(e_misses));
        txn_load(16'h0054, 16'h3333, 1'b1);
        txn_load(16'h0056, 16'h4444, 1'b1);
`ifdef MEM_REQ_PERF_EN
        e_hits = 5;
`endif
        check("perf_hits_5",    32'(perf_hits),    32'(e_hits));
        check("perf2_hits_sat", 32'(d2_perf_hits), 32'(e2_hits));
        check("perf2_misses",   32'(d2_perf_misses), 32'(e_misses));

        // Reset in the middle of WAIT: no response, everything cleared
        issue(1'b0, 16'h0060, 16'h0);
        tick();
        tick();
        rst = 1'b0;
        #1;
        check("mrst_req_ready", 32'(req_ready), 32'd1);
        check("mrst_stall",     32'(stall_pipe), 32'd0);
        check("mrst_mem_rdwr",  32'({mem_rd, mem_wr}), 32'd0);
        check("mrst_perf",      32'({perf_hits, perf_misses}), 32'd0);
        tick();
        rst = 1'b1;
        repeat (4) tick();
        @(negedge clk);
        check("mrst_idle", 32'(req_ready), 32'd1);
        check("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
